ariele_rr_arbiter: RTL and testbench
====================================

ARIELE_RR_ARBITER -- requirements
Module: ariele_rr_arbiter

Interface
REQ-001 Parameter RDFIFO_DEPTH, default 4, depth of the outstanding-read master-ID FIFO; power of 2, 2..16.
REQ-002 clk_i  input  1  single clock, all state on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 m<N>_req_i  input  1  master N request, N=0..3.
REQ-005 m<N>_ack_o  output  1  master N request accepted.
REQ-006 m<N>_addr_bi  input  32  master N address.
REQ-007 m<N>_we_i  input  1  master N write (1) / read (0).
REQ-008 m<N>_wdata_bi  input  32  master N write data.
REQ-009 m<N>_resp_o  output  1  master N read response valid.
REQ-010 m<N>_rdata_bo  output  32  master N read data.
REQ-011 s_req_o / s_ack_i / s_addr_bo / s_we_o / s_wdata_bo  out/in/out/out/out  1/1/32/1/32  shared slave request channel.
REQ-012 s_resp_i / s_rdata_bi  input  1/32  slave read response, in request order.
REQ-013 err_o  output  1  sticky: response received with no outstanding read.

Function
REQ-014 Request transfer occurs on a cycle where req and ack are both high; masters hold req, addr, we, wdata stable until ack.
REQ-015 States: IDLE, GRANT(g), g in 0..3, registered grant index.
REQ-016 Master N eligible when m<N>_req_i=1 and (m<N>_we_i=1 or read FIFO not full).
REQ-017 IDLE -> GRANT(g) on next edge when any master eligible; g chosen by arbitration policy (REQ-028).
REQ-018 In GRANT(g): s_req_o=m<g>_req_i, s_addr_bo/s_we_o/s_wdata_bo = master g fields; other masters' acks 0.
REQ-019 m<g>_ack_o = s_ack_i & s_req_o in GRANT(g), combinational; 0 in IDLE.
REQ-020 On handshake in GRANT(g): re-arbitrate same cycle over current eligibility; next state GRANT(new) if any eligible, else IDLE; back-to-back transfers with no bubble.
REQ-021 Request-to-slave latency: exactly 1 cycle from eligible req in IDLE to s_req_o.
REQ-022 On read handshake, push g into FIFO; writes push nothing.
REQ-023 s_resp_i=1 with FIFO non-empty: m<head>_resp_o=1 same cycle, FIFO pops; all m<N>_rdata_bo = s_rdata_bi continuously.
REQ-024 s_resp_i=1 with FIFO empty: no master resp, no pop, err_o set until reset.
REQ-025 Push and pop same cycle: both take effect, occupancy unchanged; FIFO cannot overflow because reads are ineligible when full.
REQ-026 Read request blocked while FIFO full becomes eligible the cycle after a pop.

Reset
REQ-027 rst_i=1 at edge: state IDLE, FIFO empty, RR pointer=0, err_o=0; s_req_o, all acks and resps 0 from the next cycle; in-flight responses after reset are treated per REQ-024.

Configuration
REQ-028 Macro ARIELE_ARB_RR_EN: defined -> round-robin, search starts at master after last granted (pointer=0 after reset), pointer updates on each handshake; undefined -> fixed priority m0>m1>m2>m3, no pointer state.

Verification
REQ-029 Single master: m2 read 0x100 with s_ack_i=1 -> s_req_o one cycle after req, m2_ack_o same cycle as s_ack_i, m2_resp_o on s_resp_i with rdata 0x80000100.
REQ-030 All four masters requesting writes continuously, ARIELE_ARB_RR_EN defined -> grant order 0,1,2,3,0,... one handshake per cycle; undefined -> m0 only while held.
REQ-031 Five reads from m1 with RDFIFO_DEPTH=4, slave not responding -> 4 acks, 5th held; after one s_resp_i pulse, 5th acked within 2 cycles.
REQ-032 Interleaved reads m0,m3,m1 -> three s_resp_i pulses route to m0_resp_o, m3_resp_o, m1_resp_o in that order.
REQ-033 s_resp_i pulse with FIFO empty -> no m<N>_resp_o, err_o=1 held; rst_i pulse -> err_o=0.
REQ-034 rst_i asserted mid-GRANT with 2 reads outstanding -> next cycle s_req_o=0, FIFO empty, subsequent stray responses set err_o.

Source files
------------

// File: rtl/ariele_rr_arbiter_if.sv
// Bus bundle for ariele_rr_arbiter: four request/response masters and one shared slave channel.
// Modport master is the arbiter's view (it masters the shared slave); slave is the environment's view.
interface ariele_rr_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              m0_req_i, m1_req_i, m2_req_i, m3_req_i;
    logic              m0_ack_o, m1_ack_o, m2_ack_o, m3_ack_o;
    logic [DATA_W-1:0] m0_addr_bi, m1_addr_bi, m2_addr_bi, m3_addr_bi;
    logic              m0_we_i, m1_we_i, m2_we_i, m3_we_i;
    logic [DATA_W-1:0] m0_wdata_bi, m1_wdata_bi, m2_wdata_bi, m3_wdata_bi;
    logic              m0_resp_o, m1_resp_o, m2_resp_o, m3_resp_o;
    logic [DATA_W-1:0] m0_rdata_bo, m1_rdata_bo, m2_rdata_bo, m3_rdata_bo;
    logic              s_req_o, s_ack_i, s_we_o, s_resp_i, err_o;
    logic [DATA_W-1:0] s_addr_bo, s_wdata_bo, s_rdata_bi;

    modport master (
        input  m0_req_i, m1_req_i, m2_req_i, m3_req_i,
        input  m0_addr_bi, m1_addr_bi, m2_addr_bi, m3_addr_bi,
        input  m0_we_i, m1_we_i, m2_we_i, m3_we_i,
        input  m0_wdata_bi, m1_wdata_bi, m2_wdata_bi, m3_wdata_bi,
        output m0_ack_o, m1_ack_o, m2_ack_o, m3_ack_o,
        output m0_resp_o, m1_resp_o, m2_resp_o, m3_resp_o,
        output m0_rdata_bo, m1_rdata_bo, m2_rdata_bo, m3_rdata_bo,
        output s_req_o, s_addr_bo, s_we_o, s_wdata_bo, err_o,
        input  s_ack_i, s_resp_i, s_rdata_bi
    );

    modport slave (
        output m0_req_i, m1_req_i, m2_req_i, m3_req_i,
        output m0_addr_bi, m1_addr_bi, m2_addr_bi, m3_addr_bi,
        output m0_we_i, m1_we_i, m2_we_i, m3_we_i,
        output m0_wdata_bi, m1_wdata_bi, m2_wdata_bi, m3_wdata_bi,
        input  m0_ack_o, m1_ack_o, m2_ack_o, m3_ack_o,
        input  m0_resp_o, m1_resp_o, m2_resp_o, m3_resp_o,
        input  m0_rdata_bo, m1_rdata_bo, m2_rdata_bo, m3_rdata_bo,
        input  s_req_o, s_addr_bo, s_we_o, s_wdata_bo, err_o,
        output s_ack_i, s_resp_i, s_rdata_bi
    );
endinterface

// File: rtl/ariele_rr_arbiter.sv
// Four-master arbiter onto one slave, with an ID FIFO routing in-order read responses back.
// Macro ARIELE_ARB_RR_EN selects round-robin arbitration; otherwise fixed priority m0>m1>m2>m3.
module ariele_rr_arbiter #(
    parameter int RDFIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ariele_rr_arbiter_if.master bus
);
    localparam int PTR_W = (RDFIFO_DEPTH > 1) ? $clog2(RDFIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    // Returns {found, index}: first eligible master at or after start, wrapping.
    function automatic logic [2:0] pick(input logic [3:0] elig, input logic [1:0] start);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (elig[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    logic [3:0]  req, we, elig, ack, resp;
    logic [31:0] addr [4];
    logic [31:0] wdata [4];

    assign req = {bus.m3_req_i, bus.m2_req_i, bus.m1_req_i, bus.m0_req_i};
    assign we  = {bus.m3_we_i, bus.m2_we_i, bus.m1_we_i, bus.m0_we_i};
    assign addr[0]  = bus.m0_addr_bi;
    assign addr[1]  = bus.m1_addr_bi;
    assign addr[2]  = bus.m2_addr_bi;
    assign addr[3]  = bus.m3_addr_bi;
    assign wdata[0] = bus.m0_wdata_bi;
    assign wdata[1] = bus.m1_wdata_bi;
    assign wdata[2] = bus.m2_wdata_bi;
    assign wdata[3] = bus.m3_wdata_bi;

    state_t           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d, start;
    logic [2:0]       arb;
    logic             s_req, hs, push, pop, full_arb;
    logic [1:0]       mem [RDFIFO_DEPTH];
    logic [PTR_W-1:0] wp_q, rp_q;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             err_q;

    assign s_req   = (state_q == GRANT) && req[gnt_q];
    assign hs      = s_req && bus.s_ack_i;
    assign push    = hs && !we[gnt_q];
    assign pop     = bus.s_resp_i && (cnt_q != '0);
    assign cnt_nxt = cnt_q + CNT_W'(push) - CNT_W'(pop);

    // On a handshake the arbitration must see the FIFO as it will be after this read's push,
    // otherwise a read could be granted into a full FIFO.
    assign full_arb = hs ? (cnt_nxt == CNT_W'(RDFIFO_DEPTH)) : (cnt_q == CNT_W'(RDFIFO_DEPTH));
    assign elig     = req & (we | {4{!full_arb}});

`ifdef ARIELE_ARB_RR_EN
    logic [1:0] ptr_q;
    assign start = hs ? gnt_q + 2'd1 : ptr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)   ptr_q <= 2'd0;
        else if (hs) ptr_q <= gnt_q + 2'd1;
    end
`else
    assign start = 2'd0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
        end
    end

    // A granted master that drops its request is released so it cannot stall the others.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        arb     = pick(elig, start);
        if (state_q == IDLE || hs || !req[gnt_q]) begin
            if (arb[2]) begin
                state_d = GRANT;
                gnt_d   = arb[1:0];
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        ack  = 4'b0000;
        resp = 4'b0000;
        if (hs)  ack[gnt_q] = 1'b1;
        if (pop) resp[mem[rp_q]] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (push) wp_q <= wp_q + PTR_W'(1);
            if (pop)  rp_q <= rp_q + PTR_W'(1);
            cnt_q <= cnt_nxt;
            if (bus.s_resp_i && cnt_q == '0) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wp_q] <= gnt_q;
    end

    assign bus.s_req_o    = s_req;
    assign bus.s_addr_bo  = addr[gnt_q];
    assign bus.s_we_o     = we[gnt_q];
    assign bus.s_wdata_bo = wdata[gnt_q];
    assign bus.err_o      = err_q;
    assign bus.m0_ack_o   = ack[0];
    assign bus.m1_ack_o   = ack[1];
    assign bus.m2_ack_o   = ack[2];
    assign bus.m3_ack_o   = ack[3];
    assign bus.m0_resp_o  = resp[0];
    assign bus.m1_resp_o  = resp[1];
    assign bus.m2_resp_o  = resp[2];
    assign bus.m3_resp_o  = resp[3];
    assign bus.m0_rdata_bo = bus.s_rdata_bi;
    assign bus.m1_rdata_bo = bus.s_rdata_bi;
    assign bus.m2_rdata_bo = bus.s_rdata_bi;
    assign bus.m3_rdata_bo = bus.s_rdata_bi;
endmodule

// File: tb/tb_ariele_rr_arbiter.sv
// Directed bench for ariele_rr_arbiter; a queue holds the master expected for each read response.
module tb_ariele_rr_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ariele_rr_arbiter_if bus ();
    ariele_rr_arbiter #(.RDFIFO_DEPTH(4)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    logic [3:0] ack_v, resp_v;

    assign ack_v  = {bus.m3_ack_o, bus.m2_ack_o, bus.m1_ack_o, bus.m0_ack_o};
    assign resp_v = {bus.m3_resp_o, bus.m2_resp_o, bus.m1_resp_o, bus.m0_resp_o};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int n, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        case (n)
            0: begin bus.m0_req_i = req; bus.m0_we_i = we; bus.m0_addr_bi = addr; bus.m0_wdata_bi = wdata; end
            1: begin bus.m1_req_i = req; bus.m1_we_i = we; bus.m1_addr_bi = addr; bus.m1_wdata_bi = wdata; end
            2: begin bus.m2_req_i = req; bus.m2_we_i = we; bus.m2_addr_bi = addr; bus.m2_wdata_bi = wdata; end
            default: begin bus.m3_req_i = req; bus.m3_we_i = we; bus.m3_addr_bi = addr; bus.m3_wdata_bi = wdata; end
        endcase
    endtask

    // Single read from an idle arbiter with the slave always ready.
    task automatic do_read(input int n, input logic [31:0] a);
        set_m(n, 1'b1, 1'b0, a, 32'd0);
        exp_q.push_back(n);
        #1;
        check("rd_latency_idle", 32'(bus.s_req_o), 32'd0);
        tick();
        check("rd_sreq", 32'(bus.s_req_o), 32'd1);
        check("rd_addr", bus.s_addr_bo, a);
        check("rd_ack", 32'(ack_v), 32'd1 << n);
        tick();
        set_m(n, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check("rd_ack_dropped", 32'(ack_v), 32'd0);
        tick();
    endtask

    task automatic resp_pulse(input logic [31:0] d);
        logic [31:0] exp_resp;
        exp_resp = 32'd0;
        if (exp_q.size() != 0) exp_resp = 32'd1 << exp_q.pop_front();
        bus.s_resp_i   = 1'b1;
        bus.s_rdata_bi = d;
        #1;
        check("resp_route", 32'(resp_v), exp_resp);
        check("rdata_m0", bus.m0_rdata_bo, d);
        check("rdata_m3", bus.m3_rdata_bo, d);
        tick();
        bus.s_resp_i = 1'b0;
    endtask

    initial begin
        int g, cnt;
        logic seen;
        for (int n = 0; n < 4; n++) set_m(n, 1'b0, 1'b0, 32'd0, 32'd0);
        bus.s_ack_i = 1'b0; bus.s_resp_i = 1'b0; bus.s_rdata_bi = 32'd0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_sreq", 32'(bus.s_req_o), 32'd0);
        check("rst_acks", 32'(ack_v), 32'd0);
        check("rst_resps", 32'(resp_v), 32'd0);
        check("rst_err", 32'(bus.err_o), 32'd0);

        // All four masters writing continuously.
        bus.s_ack_i = 1'b1;
        for (int n = 0; n < 4; n++) set_m(n, 1'b1, 1'b1, 32'hA000_0000 | n, 32'hD000_0000 | n);
        for (int c = 0; c < 8; c++) begin
            tick();
`ifdef ARIELE_ARB_RR_EN
            g = c % 4;
`else
            g = 0;
`endif
            check("wr_grant", 32'(ack_v), 32'd1 << g);
            check("wr_wdata", bus.s_wdata_bo, 32'hD000_0000 | g);
            check("wr_we", 32'(bus.s_we_o), 32'd1);
        end
        for (int n = 0; n < 4; n++) set_m(n, 1'b0, 1'b0, 32'd0, 32'd0);
        tick(); tick();
        check("wr_idle", 32'(bus.s_req_o), 32'd0);

        // Single read from m2.
        do_read(2, 32'h0000_0100);
        resp_pulse(32'h8000_0100);
        check("rd_err_clear", 32'(bus.err_o), 32'd0);

        // Interleaved reads m0, m3, m1 routed back in order.
        do_read(0, 32'h0000_0010);
        do_read(3, 32'h0000_0030);
        do_read(1, 32'h0000_0020);
        resp_pulse(32'h1111_0000);
        resp_pulse(32'h3333_0000);
        resp_pulse(32'h2222_0000);

        // Five reads from m1 against a silent slave: FIFO fills after four.
        set_m(1, 1'b1, 1'b0, 32'h0000_0200, 32'd0);
        for (int i = 0; i < 5; i++) exp_q.push_back(1);
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (ack_v[1]) cnt++;
        end
        check("full_ack_count", cnt, 32'd4);
        check("full_held", 32'(ack_v), 32'd0);
        resp_pulse(32'h0000_0A01);
        seen = 1'b0;
        for (int c = 0; c < 2 && !seen; c++) begin
            tick();
            if (ack_v[1]) seen = 1'b1;
        end
        check("unblock_ack", 32'(seen), 32'd1);
        tick();
        set_m(1, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        for (int i = 0; i < 4; i++) resp_pulse(32'h0000_0A02 + i);

        // Stray response with nothing outstanding.
        resp_pulse(32'hDEAD_0000);
        #1;
        check("stray_err", 32'(bus.err_o), 32'd1);
        tick();
        check("stray_err_held", 32'(bus.err_o), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("err_cleared", 32'(bus.err_o), 32'd0);

        // Reset mid-grant with two reads outstanding.
        do_read(0, 32'h0000_0300);
        do_read(2, 32'h0000_0304);
        bus.s_ack_i = 1'b0;
        set_m(3, 1'b1, 1'b1, 32'h0000_0308, 32'h0000_0055);
        tick();
        check("midgrant_sreq", 32'(bus.s_req_o), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("postrst_sreq", 32'(bus.s_req_o), 32'd0);
        check("postrst_acks", 32'(ack_v), 32'd0);
        set_m(3, 1'b0, 1'b0, 32'd0, 32'd0);
        exp_q.delete();
        resp_pulse(32'hBAD0_0001);
        #1;
        check("postrst_stray_err", 32'(bus.err_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
